// File: rtl/nvram_upload_responder.sv
// Answers HPS ioctl upload requests for one index by pausing the core and
// streaming its RAM (hiscore/NVRAM) back over ioctl_din, one byte per ioctl_rd.
module nvram_upload_responder #(
    parameter logic [7:0] INDEX  = 8'd4,
    parameter int         AW     = 10,
    parameter int         SIZE   = 1024,
    parameter int         RD_LAT = 2,
    parameter logic [7:0] PAD    = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_rd,
    input  logic [24:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic          ioctl_wait,
    output logic          core_pause_req,
    input  logic          core_pause_ack,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH
    } state_t;

    localparam logic [24:0] SIZE_LIMIT = 25'(SIZE);
    localparam logic [2:0]  LAT_START  = 3'(RD_LAT);

    state_t        state_q;
    logic [7:0]    din_q;
    logic          wait_q;
    logic          pause_q;
    logic [AW-1:0] addr_q;
    logic          rd_q;
    logic [2:0]    cnt_q;

    logic          sel;
    logic          in_range;
    logic [2:0]    cnt_d;

    assign sel      = ioctl_upload && (ioctl_index == INDEX);
    // Full-width compare: high address bits set must never alias into the RAM.
    assign in_range = ioctl_addr < SIZE_LIMIT;
    assign cnt_d    = cnt_q - 3'd1;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            din_q   <= 8'h00;
            wait_q  <= 1'b0;
            pause_q <= 1'b0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            rd_q <= 1'b0;
            if (state_q != IDLE && !sel) begin
                // Upload ended or retargeted: release the core and drop any fetch.
                state_q <= IDLE;
                wait_q  <= 1'b0;
                pause_q <= 1'b0;
                cnt_q   <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (sel) begin
                            state_q <= PAUSE;
                            pause_q <= 1'b1;
                            wait_q  <= 1'b1;
                        end
                    end
                    PAUSE: begin
                        if (core_pause_ack) begin
                            state_q <= READY;
                            wait_q  <= 1'b0;
                        end
                    end
                    READY: begin
                        if (ioctl_rd) begin
                            if (in_range) begin
                                state_q <= FETCH;
                                addr_q  <= ioctl_addr[AW-1:0];
                                rd_q    <= 1'b1;
                                wait_q  <= 1'b1;
                                cnt_q   <= LAT_START;
                            end else begin
                                din_q <= PAD;
                            end
                        end
                    end
                    FETCH: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 3'd1) begin
                            din_q   <= mem_data;
                            wait_q  <= 1'b0;
                            state_q <= READY;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ioctl_din      = din_q;
    assign ioctl_wait     = wait_q;
    assign core_pause_req = pause_q;
    assign mem_addr       = addr_q;
    assign mem_rd         = rd_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_nvram_upload_responder.sv
// Randomised bench for nvram_upload_responder: a RAM image plus a transaction-level
// model of the expected HPS-visible byte, wait timing and read-strobe count.
module tb_nvram_upload_responder;

    localparam logic [7:0] INDEX  = 8'd4;
    localparam int         AW     = 10;
    localparam int         SIZE   = 1024;
    localparam int         RD_LAT = 2;
    localparam logic [7:0] PAD    = 8'hFF;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic          ioctl_rd = 1'b0;
    logic [24:0]   ioctl_addr = 25'd0;
    logic [7:0]    ioctl_din;
    logic          ioctl_wait;
    logic          core_pause_req;
    logic          core_pause_ack = 1'b0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [7:0]    mem_data;
    logic          busy;

    nvram_upload_responder #(
        .INDEX(INDEX), .AW(AW), .SIZE(SIZE), .RD_LAT(RD_LAT), .PAD(PAD)
    ) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index),
        .ioctl_rd(ioctl_rd),
        .ioctl_addr(ioctl_addr),
        .ioctl_din(ioctl_din),
        .ioctl_wait(ioctl_wait),
        .core_pause_req(core_pause_req),
        .core_pause_ack(core_pause_ack),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .busy(busy)
    );

    always #5 clk_sys = ~clk_sys;

    // Core RAM: data appears RD_LAT-1 edges after the strobe edge, garbage otherwise.
    logic [7:0] ram [0:SIZE-1];
    logic [7:0] memReg = 8'h00;
    int         memRdCount = 0;

    assign mem_data = memReg;

    always @(posedge clk_sys) begin
        if (mem_rd) begin
            memReg     <= ram[mem_addr];
            memRdCount <= memRdCount + 1;
        end else begin
            memReg <= 8'($urandom);
        end
    end

    int            vectorCount = 0;
    int            missCount = 0;
    int            expectedRdCount = 0;
    logic [7:0]    modelDin = 8'h00;
    logic [AW-1:0] modelMemAddr = '0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic upload, input logic [7:0] index, input logic rd,
                                 input logic [24:0] addr, input logic ack);
        ioctl_upload   = upload;
        ioctl_index    = index;
        ioctl_rd       = rd;
        ioctl_addr     = addr;
        core_pause_ack = ack;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_wait"}, 32'(ioctl_wait), 32'd0);
        checkOutput({tag, "_pause"}, 32'(core_pause_req), 32'd0);
        checkOutput({tag, "_memrd"}, 32'(mem_rd), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_din"}, 32'(ioctl_din), 32'(modelDin));
        checkOutput({tag, "_memaddr"}, 32'(mem_addr), 32'(modelMemAddr));
    endtask

    task automatic startUpload(input int ackDelay);
        applyStimulus(1'b1, INDEX, 1'b0, 25'd0, 1'b0);
        checkOutput("up_pause", 32'(core_pause_req), 32'd1);
        checkOutput("up_wait", 32'(ioctl_wait), 32'd1);
        checkOutput("up_busy", 32'(busy), 32'd1);
        for (int i = 0; i < ackDelay; i++) begin
            applyStimulus(1'b1, INDEX, 1'($urandom_range(0, 1)), 25'($urandom), 1'b0);
            checkOutput("pause_wait", 32'(ioctl_wait), 32'd1);
            checkOutput("pause_memrd", 32'(mem_rd), 32'd0);
        end
        applyStimulus(1'b1, INDEX, 1'b0, 25'd0, 1'b1);
        checkOutput("ack_wait", 32'(ioctl_wait), 32'd0);
        checkOutput("ack_pause", 32'(core_pause_req), 32'd1);
        checkOutput("ack_din", 32'(ioctl_din), 32'(modelDin));
    endtask

    task automatic readByte(input logic [24:0] addr, input logic violate);
        if (addr < 25'(SIZE)) begin
            applyStimulus(1'b1, INDEX, 1'b1, addr, 1'($urandom_range(0, 1)));
            modelMemAddr = addr[AW-1:0];
            checkOutput("rd_strobe", 32'(mem_rd), 32'd1);
            checkOutput("rd_addr", 32'(mem_addr), 32'(modelMemAddr));
            checkOutput("rd_wait", 32'(ioctl_wait), 32'd1);
            checkOutput("rd_din_hold", 32'(ioctl_din), 32'(modelDin));
            for (int k = 1; k <= RD_LAT; k++) begin
                applyStimulus(1'b1, INDEX, violate, 25'($urandom), 1'($urandom_range(0, 1)));
                if (k < RD_LAT) begin
                    checkOutput("fetch_memrd", 32'(mem_rd), 32'd0);
                    checkOutput("fetch_wait", 32'(ioctl_wait), 32'd1);
                    checkOutput("fetch_din_hold", 32'(ioctl_din), 32'(modelDin));
                end
            end
            modelDin = ram[addr[AW-1:0]];
            expectedRdCount++;
            checkOutput("data_din", 32'(ioctl_din), 32'(modelDin));
            checkOutput("data_wait", 32'(ioctl_wait), 32'd0);
            checkOutput("data_memrd", 32'(mem_rd), 32'd0);
            checkOutput("data_busy", 32'(busy), 32'd1);
        end else begin
            applyStimulus(1'b1, INDEX, 1'b1, addr, 1'($urandom_range(0, 1)));
            modelDin = PAD;
            checkOutput("pad_din", 32'(ioctl_din), 32'(modelDin));
            checkOutput("pad_wait", 32'(ioctl_wait), 32'd0);
            checkOutput("pad_memrd", 32'(mem_rd), 32'd0);
            checkOutput("pad_memaddr", 32'(mem_addr), 32'(modelMemAddr));
        end
    endtask

    function automatic logic [24:0] randomOutOfRange();
        logic [24:0] a;
        case ($urandom_range(0, 3))
            0:       a = 25'(SIZE);
            1:       a = 25'h1FFFFFF;
            2:       a = 25'($urandom_range(SIZE, 2 * SIZE - 1));
            default: a = 25'($urandom) | (25'd1 << $urandom_range(10, 24));
        endcase
        return a;
    endfunction

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] badIdx;
        logic [24:0] a;
        int waited;
        int seqBase;

        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
        ram[18] = 8'hA5;

        repeat (3) applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0);
        checkIdle("reset");
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0);
        checkIdle("post_reset");

        // Foreign indices and idle upload line must be ignored completely.
        for (int i = 0; i < 24; i++) begin
            case (i % 4)
                0:       badIdx = 8'd0;
                1:       badIdx = 8'd254;
                2:       badIdx = 8'd5;
                default: begin
                    badIdx = 8'($urandom);
                    if (badIdx == INDEX) badIdx = 8'd3;
                end
            endcase
            applyStimulus(1'b1, badIdx, 1'($urandom_range(0, 1)), 25'($urandom_range(0, SIZE - 1)),
                          1'($urandom_range(0, 1)));
            checkIdle("foreign_idx");
        end
        applyStimulus(1'b0, INDEX, 1'b1, 25'd5, 1'b1);
        checkIdle("no_upload");

        startUpload(5);
        readByte(25'h012, 1'b0);
        readByte(25'h400, 1'b0);

        // Upload dropped one cycle into a fetch: abort, keep last byte.
        applyStimulus(1'b1, INDEX, 1'b1, 25'h0AB, 1'b1);
        modelMemAddr = 10'h0AB;
        checkOutput("abort_strobe", 32'(mem_rd), 32'd1);
        applyStimulus(1'b0, INDEX, 1'b0, 25'd0, 1'b1);
        expectedRdCount++;
        checkIdle("abort");
        applyStimulus(1'b0, INDEX, 1'b0, 25'd0, 1'b0);
        checkIdle("abort_hold");

        // Random mix of in-range, out-of-range, idle and retarget events.
        startUpload(int'($urandom_range(1, 6)));
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: readByte(25'($urandom_range(0, SIZE - 1)), 1'($urandom_range(0, 1)));
                6, 7: readByte(randomOutOfRange(), 1'b0);
                8: begin
                    applyStimulus(1'b1, INDEX, 1'b0, 25'($urandom), 1'($urandom_range(0, 1)));
                    checkOutput("hold_din", 32'(ioctl_din), 32'(modelDin));
                    checkOutput("hold_wait", 32'(ioctl_wait), 32'd0);
                end
                default: begin
                    applyStimulus(1'b1, 8'd5, 1'b0, 25'd0, 1'b1);
                    checkIdle("retarget");
                    startUpload(int'($urandom_range(0, 4)));
                end
            endcase
        end

        // Full sequential dump with the HPS honouring wait.
        seqBase = memRdCount;
        for (int i = 0; i < SIZE; i++) begin
            applyStimulus(1'b1, INDEX, 1'b1, 25'(i), 1'b1);
            waited = 0;
            while (ioctl_wait && waited < 20) begin
                applyStimulus(1'b1, INDEX, 1'b0, 25'd0, 1'b1);
                waited++;
            end
            modelDin = ram[i];
            expectedRdCount++;
            checkOutput("seq_wait_cycles", 32'(waited), 32'(RD_LAT));
            checkOutput("seq_byte", 32'(ioctl_din), 32'(modelDin));
        end
        applyStimulus(1'b1, INDEX, 1'b0, 25'd0, 1'b1);
        checkOutput("seq_rd_count", 32'(memRdCount - seqBase), 32'(SIZE));
        checkOutput("total_rd_count", 32'(memRdCount), 32'(expectedRdCount));

        // Asynchronous reset in the middle of a fetch.
        a = 25'($urandom_range(0, SIZE - 1));
        applyStimulus(1'b1, INDEX, 1'b1, a, 1'b1);
        checkOutput("pre_reset_strobe", 32'(mem_rd), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        modelDin = 8'h00;
        modelMemAddr = '0;
        checkIdle("async_reset");
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b0, 8'd0, 1'b0, 25'd0, 1'b0);
        checkIdle("after_async_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
